// File: rtl/wb_stage_pkg.sv
// Shared writeback-core definitions: datapath widths, load-type encoding,
// the writeback entry record and the load byte/half extraction helper.
package wb_stage_pkg;

  localparam int unsigned CORE_WIDTH      = 32;
  localparam int unsigned CORE_ADDR_WIDTH = 5;

  // RV32I load funct3 encodings
  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_type_e;

  typedef struct packed {
    logic [CORE_ADDR_WIDTH-1:0] rd;
    logic [CORE_WIDTH-1:0]      data;
  } wb_entry_t;

  // Unlisted funct3 codes fall back to a full-word load.
  function automatic logic [CORE_WIDTH-1:0] load_extract(
    input logic [2:0]            funct3,
    input logic [CORE_WIDTH-1:0] raw
  );
    logic [CORE_WIDTH-1:0] res;
    case (funct3)
      LD_LB:   res = {{(CORE_WIDTH-8){raw[7]}}, raw[7:0]};
      LD_LH:   res = {{(CORE_WIDTH-16){raw[15]}}, raw[15:0]};
      LD_LBU:  res = {{(CORE_WIDTH-8){1'b0}}, raw[7:0]};
      LD_LHU:  res = {{(CORE_WIDTH-16){1'b0}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_stage_load_queue.sv
// wb_load_queue: parameterised in-order FIFO with occupancy count and
// full/empty flags. Pushes while full and pops while empty are ignored.
module wb_load_queue #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; not reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: merges ALU results and out-of-band load responses onto the
// single register-file write port. Loads are tracked in an in-order queue;
// an ALU result that loses to a load response is parked in a one-entry skid.
// Optional macro WB_BYPASS_EN adds two read-bypass compare ports.
// WIDTH/ADDR_WIDTH must stay equal to the package widths (wb_entry_t).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned WIDTH      = wb_stage_pkg::CORE_WIDTH,
  parameter int unsigned ADDR_WIDTH = wb_stage_pkg::CORE_ADDR_WIDTH,
  parameter int unsigned LQ_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_WIDTH-1:0]       alu_rd,
  input  logic [WIDTH-1:0]            alu_data,
  input  logic                        ld_issue_valid,
  output logic                        ld_issue_ready,
  input  logic [ADDR_WIDTH-1:0]       ld_rd,
  input  logic [2:0]                  ld_funct3,
  input  logic                        ld_rsp_valid,
  input  logic [WIDTH-1:0]            ld_rsp_data,
  output logic                        lq_err,
  output logic [$clog2(LQ_DEPTH):0]   lq_count,
  output logic                        dest_en,
  output logic [ADDR_WIDTH-1:0]       dest_addr,
  output logic [WIDTH-1:0]            dest_data
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_WIDTH-1:0]       byp_rs1_addr,
  input  logic [ADDR_WIDTH-1:0]       byp_rs2_addr,
  output logic                        byp_rs1_hit,
  output logic [WIDTH-1:0]            byp_rs1_data,
  output logic                        byp_rs2_hit,
  output logic [WIDTH-1:0]            byp_rs2_data
`endif
);

  localparam int unsigned QW = ADDR_WIDTH + 3;

  logic [QW-1:0] q_push_data;
  logic [QW-1:0] q_pop_data;
  logic          q_full;
  logic          q_empty;
  logic          ld_push;
  logic          rsp_hit;
  logic          rsp_miss;
  logic          alu_fire;
  logic          skid_valid;
  wb_entry_t     skid;
  logic          sel_valid;
  wb_entry_t     sel;

  assign ld_issue_ready = ~q_full;
  assign alu_ready      = ~skid_valid;
  assign ld_push        = ld_issue_valid & ld_issue_ready;
  assign alu_fire       = alu_valid & alu_ready;
  assign rsp_hit        = ld_rsp_valid & ~q_empty;
  assign rsp_miss       = ld_rsp_valid & q_empty;
  assign q_push_data    = {ld_rd, ld_funct3};

  wb_load_queue #(
    .DW    (QW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ld_push),
    .push_data (q_push_data),
    .pop       (rsp_hit),
    .pop_data  (q_pop_data),
    .count     (lq_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Write-port arbitration: load response, then skid entry, then fresh ALU.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    if (rsp_hit) begin
      sel_valid = 1'b1;
      sel.rd    = q_pop_data[QW-1:3];
      sel.data  = load_extract(q_pop_data[2:0], ld_rsp_data);
    end else if (skid_valid) begin
      sel_valid = 1'b1;
      sel       = skid;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel.rd    = alu_rd;
      sel.data  = alu_data;
    end
  end

  // Skid: capture an ALU result beaten by a load, release it once the port is free.
  // alu_fire cannot coincide with a full skid, so capture and drain never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
      skid       <= '0;
    end else if (rsp_hit && alu_fire) begin
      skid_valid <= 1'b1;
      skid.rd    <= alu_rd;
      skid.data  <= alu_data;
    end else if (!rsp_hit) begin
      skid_valid <= 1'b0;
    end
  end

  // Registered write port; x0 writes are consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_en   <= 1'b0;
      dest_addr <= '0;
      dest_data <= '0;
    end else begin
      dest_en <= sel_valid && (sel.rd != '0);
      if (sel_valid) begin
        dest_addr <= sel.rd;
        dest_data <= sel.data;
      end
    end
  end

  // Sticky flag for a response that had no outstanding load to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lq_err <= 1'b0;
    else if (rsp_miss) lq_err <= 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign byp_rs1_hit  = dest_en && (byp_rs1_addr == dest_addr) && (byp_rs1_addr != '0);
  assign byp_rs1_data = dest_data;
  assign byp_rs2_hit  = dest_en && (byp_rs2_addr == dest_addr) && (byp_rs2_addr != '0);
  assign byp_rs2_data = dest_data;
`else
  // No bypass compare logic in this build.
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the core register file.
- Merges two result sources into the regfile's single write port (dest_en/dest_addr/dest_data): single-cycle ALU results, and load responses that return out of band from memory.
- Tracks outstanding loads in an in-order queue.
- Arbitrates collisions with a one-entry ALU skid buffer.
- Performs load byte/half extraction and sign extension.

Parameters:
- WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, register address width.
- LQ_DEPTH, 4, outstanding-load queue entries (power of two, ≥2).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  stage can accept the ALU result this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination.
- alu_data  in  WIDTH  ALU result.
- ld_issue_valid  in  1  load issued to memory.
- ld_issue_ready  out  1  queue has room.
- ld_rd  in  ADDR_WIDTH  load destination.
- ld_funct3  in  3  load type (RV32I encoding).
- ld_rsp_valid  in  1  memory response present (always consumed).
- ld_rsp_data  in  WIDTH  response data, LSB-aligned.
- lq_err  out  1  sticky: response arrived with empty queue.
- lq_count  out  $clog2(LQ_DEPTH)+1  outstanding loads.
- dest_en  out  1  regfile write enable.
- dest_addr  out  ADDR_WIDTH  regfile write address.
- dest_data  out  WIDTH  regfile write data.

Behaviour:
- Reset values (async on rst_n low):
  - dest_en=0, dest_addr=0, dest_data=0.
  - lq_err=0, lq_count=0.
  - Queue and skid buffer empty.
  - alu_ready=1, ld_issue_ready=1.
- Reset mid-operation flushes all pending loads and any skid entry without writing them.
- Handshakes: a transfer occurs when valid&ready are both high at a rising edge. Valid must not depend on ready.
- ld_issue_ready = (lq_count < LQ_DEPTH), from registered state only. A pop in the same cycle does not free a slot until the next cycle.
- alu_ready = ~skid_full, registered-state only.
- Load queue:
  - FIFO of {rd, funct3}; pushed on issue handshake, popped on ld_rsp_valid.
  - Push and pop may occur in the same cycle; lq_count is unchanged.
  - Pointers wrap modulo LQ_DEPTH.
- Empty-queue response: ld_rsp_valid with lq_count==0 (registered) is dropped, sets lq_err (cleared only by reset), and writes nothing. A response to a load issued in the same cycle counts as empty.
- Write-source priority each cycle:
  1. Load response.
  2. Skid entry.
  3. Fresh ALU handshake.
- Loser handling:
  - A fresh ALU handshake that loses arbitration goes into the skid buffer.
  - The skid entry drains on the first cycle without a load response.
  - Skid and fresh ALU never both enter; alu_ready=0 while the skid is full.
- Write latency: the winner appears on dest_* exactly one cycle after selection (registered outputs). dest_en pulses for one cycle per write; dest_addr/dest_data hold their last value when dest_en=0.
- rd==0: the selected entry is consumed but dest_en stays 0. dest_addr/dest_data still update.
- Load extraction, by funct3:
  - 000 LB: sign-extend [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: full word.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - Other codes are treated as LW.
- Ordering: loads retire in issue order. ALU writes may overtake pending loads. WAW hazard avoidance is the issue stage's job.

Optional Feature:
- WB_BYPASS_EN.
- When defined, adds:
  - Inputs byp_rs1_addr and byp_rs2_addr (ADDR_WIDTH).
  - Outputs byp_rs1_hit, byp_rs1_data, byp_rs2_hit, byp_rs2_data.
- Bypass behaviour: combinationally compares each address against the registered dest_* and asserts hit when dest_en & addr match & addr≠0, with data=dest_data. This covers the regfile write-then-read cycle.
- Without the macro these ports do not exist and no compare logic is built.

Decomposition:
- Shared core package holds:
  - WIDTH and ADDR_WIDTH constants.
  - A funct3 load-type enum (LB/LH/LW/LBU/LHU).
  - A wb_entry_t struct {rd, data}.
- Sub-module wb_load_queue: a parameterised FIFO with count, full and empty. It is reusable by the LSU.
- Load extraction is a function in the package.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF → next cycle dest_en=1, dest_addr=5, dest_data=0xDEADBEEF; alu_ready stays 1.
- Collision: issue LB rd=3, then in the same cycle alu(rd=7, 0x11) and rsp 0x00000080 → cycle+1 writes x3=0xFFFFFF80; cycle+2 writes x7=0x11; alu_ready=0 during cycle+1.
- Queue full: 4 issues with no responses → lq_count=4, ld_issue_ready=0; one response pops, and ready returns only on the following cycle.
- Extraction: rsp 0x0000F0F0 for LH, LHU, LBU → 0xFFFFF0F0, 0x0000F0F0, 0x000000F0.
- x0 and error: ALU rd=0 gives no dest_en. A response with an empty queue gives lq_err=1 with no write, and lq_err stays set until rst_n low.
- Reset mid-flight: 2 loads pending plus a full skid, pulse rst_n low asynchronously → all outputs return to reset values immediately; later responses set lq_err.
